// File: rtl/bop_interval_table_pkg.sv
// Shared types for the buffer-overflow-protection interval table.
// Entry fields are sized for the widest supported address; narrower tables zero-extend.
package bop_pkg;

    localparam int unsigned BOP_ADDR_W = 32;
    localparam int unsigned BOP_DEPTH  = 4;
    localparam int unsigned BOP_AGE_W  = 8;

    typedef struct packed {
        logic                  valid;
        logic [BOP_ADDR_W-1:0] first;
        logic [BOP_ADDR_W-1:0] last;
        logic                  big;
        logic [BOP_AGE_W-1:0]  age;
    } bop_interval_t;

    function automatic logic [BOP_AGE_W-1:0] bop_age_inc(input logic [BOP_AGE_W-1:0] age,
                                                         input logic [BOP_AGE_W-1:0] max_age);
        return (age < max_age) ? age + BOP_AGE_W'(1) : max_age;
    endfunction

endpackage

// File: rtl/bop_interval_table_if.sv
// Write, query and status signals of the interval table.
// The master drives writes and queries; the slave (table) returns hits and status.
interface bop_interval_table_if import bop_pkg::*; #(
    parameter int unsigned ADDR_W = BOP_ADDR_W,
    parameter int unsigned DEPTH  = BOP_DEPTH
);
    logic                         flush_i;
    logic                         wr_en_i;
    logic [ADDR_W-1:0]            wr_first_i;
    logic [ADDR_W-1:0]            wr_last_i;
    logic                         wr_big_i;
    logic [ADDR_W-1:0]            query_addr_i;
    logic                         hit_o;
    logic                         hit_first_o;
    logic                         hit_big_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         full_o;
    logic                         evict_o;
    logic                         drop_o;

    modport master (
        output flush_i, wr_en_i, wr_first_i, wr_last_i, wr_big_i, query_addr_i,
        input  hit_o, hit_first_o, hit_big_o, count_o, full_o, evict_o, drop_o
    );

    modport slave (
        input  flush_i, wr_en_i, wr_first_i, wr_last_i, wr_big_i, query_addr_i,
        output hit_o, hit_first_o, hit_big_o, count_o, full_o, evict_o, drop_o
    );
endinterface

// File: rtl/bop_victim_select.sv
// Slot selection for an interval write: merge target, free slot and eviction victim.
// All choices use lowest-index priority; the victim prefers the oldest non-big entry.
module bop_victim_select import bop_pkg::*; #(
    parameter int unsigned DEPTH = BOP_DEPTH,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  bop_interval_t [DEPTH-1:0] entries_i,
    input  logic [DEPTH-1:0]          match_i,
    output logic                      merge_hit_o,
    output logic [IDX_W-1:0]          merge_idx_o,
    output logic                      free_hit_o,
    output logic [IDX_W-1:0]          free_idx_o,
    output logic [IDX_W-1:0]          victim_idx_o
);

    logic                 nb_found;
    logic [IDX_W-1:0]     nb_idx;
    logic [BOP_AGE_W-1:0] nb_age;
    logic [IDX_W-1:0]     any_idx;
    logic [BOP_AGE_W-1:0] any_age;

    // Scanning downwards leaves the lowest matching index as the final assignment.
    always_comb begin
        merge_hit_o = 1'b0;
        merge_idx_o = '0;
        free_hit_o  = 1'b0;
        free_idx_o  = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (match_i[i-1]) begin
                merge_hit_o = 1'b1;
                merge_idx_o = IDX_W'(i-1);
            end
            if (!entries_i[i-1].valid) begin
                free_hit_o = 1'b1;
                free_idx_o = IDX_W'(i-1);
            end
        end
    end

    // Strict greater-than keeps the lowest index on age ties.
    always_comb begin
        nb_found = 1'b0;
        nb_idx   = '0;
        nb_age   = '0;
        any_idx  = '0;
        any_age  = entries_i[0].age;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!entries_i[i].big && (!nb_found || entries_i[i].age > nb_age)) begin
                nb_found = 1'b1;
                nb_idx   = IDX_W'(i);
                nb_age   = entries_i[i].age;
            end
            if (entries_i[i].age > any_age) begin
                any_idx = IDX_W'(i);
                any_age = entries_i[i].age;
            end
        end
        victim_idx_o = nb_found ? nb_idx : any_idx;
    end

endmodule

// File: rtl/bop_interval_table.sv
// Buffer-overflow interval table: stores store-overflow intervals, merges adjacent ones,
// evicts by age (big entries last) and answers combinational load-address range queries.
module bop_interval_table import bop_pkg::*; #(
    parameter int unsigned DEPTH  = BOP_DEPTH,
    parameter int unsigned ADDR_W = BOP_ADDR_W
) (
    input logic               clk_i,
    input logic               rst_ni,
    bop_interval_table_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned EXT_W = BOP_ADDR_W + 1;

    typedef logic [EXT_W-1:0] ext_t;

    bop_interval_t [DEPTH-1:0] entries_q, entries_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      full_q, full_d;
    logic                      evict_q, evict_d;
    logic                      drop_q, drop_d;

    logic [ADDR_W-1:0]     wr_first_raw, wr_last_raw, query_raw;
    logic [BOP_ADDR_W-1:0] wr_first, wr_last, query;
    logic [DEPTH-1:0]      match;
    logic                  merge_hit, free_hit;
    logic [IDX_W-1:0]      merge_idx, free_idx, victim_idx, slot;

    assign wr_first_raw = bus.wr_first_i;
    assign wr_last_raw  = bus.wr_last_i;
    assign query_raw    = bus.query_addr_i;
    assign wr_first     = BOP_ADDR_W'(wr_first_raw);
    assign wr_last      = BOP_ADDR_W'(wr_last_raw);
    assign query        = BOP_ADDR_W'(query_raw);

    // Overlap-or-adjacent test; the +1 is one bit wider so the all-ones address cannot wrap.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = entries_q[i].valid &&
                       (ext_t'(entries_q[i].first) <= ext_t'(wr_last) + ext_t'(1)) &&
                       (ext_t'(wr_first) <= ext_t'(entries_q[i].last) + ext_t'(1));
        end
    end

    bop_victim_select #(.DEPTH(DEPTH)) u_victim_select (
        .entries_i   (entries_q),
        .match_i     (match),
        .merge_hit_o (merge_hit),
        .merge_idx_o (merge_idx),
        .free_hit_o  (free_hit),
        .free_idx_o  (free_idx),
        .victim_idx_o(victim_idx)
    );

    assign slot = free_hit ? free_idx : victim_idx;

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        evict_d   = 1'b0;
        drop_d    = 1'b0;
        if (bus.flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            count_d = '0;
        end else if (bus.wr_en_i) begin
            if (wr_last < wr_first) begin
                drop_d = 1'b1;
            end else if (merge_hit) begin
                if (wr_first < entries_q[merge_idx].first) entries_d[merge_idx].first = wr_first;
                if (wr_last > entries_q[merge_idx].last)   entries_d[merge_idx].last  = wr_last;
                entries_d[merge_idx].big = entries_q[merge_idx].big | bus.wr_big_i;
                entries_d[merge_idx].age = '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (entries_q[i].valid && IDX_W'(i) != slot) begin
                        entries_d[i].age = bop_age_inc(entries_q[i].age, BOP_AGE_W'(DEPTH-1));
                    end
                end
                entries_d[slot].valid = 1'b1;
                entries_d[slot].first = wr_first;
                entries_d[slot].last  = wr_last;
                entries_d[slot].big   = bus.wr_big_i;
                entries_d[slot].age   = '0;
                if (free_hit) count_d = count_q + CNT_W'(1);
                else          evict_d = 1'b1;
            end
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            evict_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            full_q    <= full_d;
            evict_q   <= evict_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        bus.hit_o       = 1'b0;
        bus.hit_first_o = 1'b0;
        bus.hit_big_o   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && query >= entries_q[i].first && query <= entries_q[i].last) begin
                bus.hit_o = 1'b1;
                if (entries_q[i].big) bus.hit_big_o = 1'b1;
            end
            if (entries_q[i].valid && query == entries_q[i].first) bus.hit_first_o = 1'b1;
        end
    end

    assign bus.count_o = count_q;
    assign bus.full_o  = full_q;
    assign bus.evict_o = evict_q;
    assign bus.drop_o  = drop_q;

endmodule
